// File: rtl/tsu_pkg.sv
// tsu_pkg: shared definitions for the tsu timestamp queue read side.
//   tsu_state_e : encoding of the queue-reader FSM
//   TS_W0..TS_W3: host word select values within a 128-bit timestamp entry
//   TS_ENTRY_W  : width of one queue entry
//   HOST_W      : host register bus width
//   ts_word()   : extracts one host word from an entry
package tsu_pkg;

  localparam int TS_ENTRY_W = 128;
  localparam int HOST_W     = 32;

  localparam logic [1:0] TS_W0 = 2'd0;  // [31:0]
  localparam logic [1:0] TS_W1 = 2'd1;  // [63:32]
  localparam logic [1:0] TS_W2 = 2'd2;  // [95:64]
  localparam logic [1:0] TS_W3 = 2'd3;  // [127:96]

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_SETTLE
  } tsu_state_e;

  function automatic logic [HOST_W-1:0] ts_word(input logic [TS_ENTRY_W-1:0] entry,
                                                input logic [1:0]            sel);
    case (sel)
      TS_W3:   return entry[127:96];
      TS_W2:   return entry[95:64];
      TS_W1:   return entry[63:32];
      default: return entry[31:0];
    endcase
  endfunction

endpackage

// File: rtl/tsu_qrd_fsm.sv
// tsu_qrd_fsm: sequencing for popping one tsu queue entry at a time.
// Ports:
//   q_rd_clk  in  clock
//   rst_n     in  asynchronous active-low reset
//   q_rd_stat in  queue occupancy (0 = empty)
//   ts_valid  in  holding register already contains an unread entry
//   pop       in  host has consumed the held entry this cycle
//   q_rd_en   out registered one-cycle pop strobe to the queue
//   capture   out load q_rd_data into the holding register this cycle
module tsu_qrd_fsm
  import tsu_pkg::*;
#(
  parameter int RD_LATENCY  = 1,
  parameter int STAT_SETTLE = 2,
  parameter int STAT_W      = 8
) (
  input  logic              q_rd_clk,
  input  logic              rst_n,
  input  logic [STAT_W-1:0] q_rd_stat,
  input  logic              ts_valid,
  input  logic              pop,
  output logic              q_rd_en,
  output logic              capture
);

  localparam logic [7:0] LAT_C    = 8'(RD_LATENCY);
  localparam logic [7:0] SETTLE_C = 8'(STAT_SETTLE);

  tsu_state_e state;
  logic [7:0] cnt;

  // Data is present RD_LATENCY cycles after the strobe; the counter starts at 1
  // in the first WAIT cycle so capture lands exactly on that cycle.
  assign capture = (state == ST_WAIT) && (cnt >= LAT_C);

  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      q_rd_en <= 1'b0;
    end else begin
      q_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((q_rd_stat != '0) && !ts_valid) begin
            state   <= ST_REQ;
            q_rd_en <= 1'b1;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
          cnt   <= 8'd1;
        end
        ST_WAIT: begin
          if (cnt >= LAT_C) state <= ST_HOLD;
          else              cnt   <= cnt + 8'd1;
        end
        ST_HOLD: begin
          if (pop) begin
            state <= ST_SETTLE;
            cnt   <= 8'd1;
          end
        end
        ST_SETTLE: begin
          // Occupancy from the queue lags our pop; don't trust it yet.
          if (cnt >= SETTLE_C) state <= ST_IDLE;
          else                 cnt   <= cnt + 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tsu_queue_reader.sv
// tsu_queue_reader: read-side consumer of the tsu timestamp queue.
// Pops one 128-bit entry into a holding register and serves it to the host
// as four 32-bit words; reading word 0 frees the entry.
// Optional feature macro: TSU_QREAD_IRQ_EN (enables ts_irq logic).
// Ports:
//   q_rd_clk     in   single clock
//   rst_n        in   asynchronous active-low reset
//   q_rd_stat    in   queue occupancy, 0 = empty
//   q_rd_en      out  one-cycle pop strobe to the queue
//   q_rd_data    in   queue entry, valid RD_LATENCY cycles after q_rd_en
//   host_rd_req  in   host read strobe
//   host_rd_addr in   word select (3=[127:96] .. 0=[31:0])
//   host_rd_data out  registered read data
//   host_rd_ack  out  high the cycle after host_rd_req
//   ts_valid     out  holding register has an unread entry
//   pop_cnt      out  entries popped from the queue (wrapping)
//   ts_irq       out  entry-available interrupt (0 unless TSU_QREAD_IRQ_EN)
module tsu_queue_reader
  import tsu_pkg::*;
#(
  parameter int RD_LATENCY  = 1,
  parameter int STAT_SETTLE = 2,
  parameter int STAT_W      = 8
) (
  input  logic                  q_rd_clk,
  input  logic                  rst_n,
  input  logic [STAT_W-1:0]     q_rd_stat,
  output logic                  q_rd_en,
  input  logic [TS_ENTRY_W-1:0] q_rd_data,
  input  logic                  host_rd_req,
  input  logic [1:0]            host_rd_addr,
  output logic [HOST_W-1:0]     host_rd_data,
  output logic                  host_rd_ack,
  output logic                  ts_valid,
  output logic [15:0]           pop_cnt,
  output logic                  ts_irq
);

  logic [TS_ENTRY_W-1:0] ts_hold;
  logic                  capture;
  logic                  pop;

  // Only a word-0 read of a valid entry consumes it.
  assign pop = host_rd_req && (host_rd_addr == TS_W0) && ts_valid;

  tsu_qrd_fsm #(
    .RD_LATENCY  (RD_LATENCY),
    .STAT_SETTLE (STAT_SETTLE),
    .STAT_W      (STAT_W)
  ) u_fsm (
    .q_rd_clk  (q_rd_clk),
    .rst_n     (rst_n),
    .q_rd_stat (q_rd_stat),
    .ts_valid  (ts_valid),
    .pop       (pop),
    .q_rd_en   (q_rd_en),
    .capture   (capture)
  );

  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_hold      <= '0;
      ts_valid     <= 1'b0;
      host_rd_data <= '0;
      host_rd_ack  <= 1'b0;
      pop_cnt      <= '0;
    end else begin
      host_rd_ack <= host_rd_req;
      // A read coinciding with capture sees the pre-capture (empty) state.
      if (host_rd_req)
        host_rd_data <= ts_valid ? ts_word(ts_hold, host_rd_addr) : '0;
      if (capture) begin
        ts_hold  <= q_rd_data;
        ts_valid <= 1'b1;
      end else if (pop) begin
        ts_valid <= 1'b0;
      end
      if (q_rd_en)
        pop_cnt <= pop_cnt + 16'd1;
    end
  end

`ifdef TSU_QREAD_IRQ_EN
  // Capture and pop are mutually exclusive (pop needs ts_valid, set by capture).
  always_ff @(posedge q_rd_clk or negedge rst_n) begin
    if (!rst_n)       ts_irq <= 1'b0;
    else if (capture) ts_irq <= 1'b1;
    else if (pop)     ts_irq <= 1'b0;
  end
`else
  assign ts_irq = 1'b0;
`endif

endmodule

// File: tb/tb_tsu_queue_reader.sv
module tb_tsu_queue_reader;

  localparam int STAT_SETTLE = 2;
`ifdef TSU_QREAD_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic         q_rd_clk = 1'b0;
  logic         rst_n;
  logic [7:0]   q_rd_stat = 8'd0;
  logic         q_rd_en;
  logic [127:0] q_rd_data = '0;
  logic         host_rd_req;
  logic [1:0]   host_rd_addr;
  logic [31:0]  host_rd_data;
  logic         host_rd_ack;
  logic         ts_valid;
  logic [15:0]  pop_cnt;
  logic         ts_irq;

  int errors = 0;
  int checks = 0;
  int rd_en_cnt = 0;
  int underruns = 0;
  int overlap = 0;

  logic [127:0] src_q[$];  // entries sitting in the modelled tsu queue
  logic [127:0] exp_q[$];  // entries popped, awaiting host consumption

  tsu_queue_reader #(.RD_LATENCY(1), .STAT_SETTLE(STAT_SETTLE), .STAT_W(8)) dut (
    .q_rd_clk     (q_rd_clk),
    .rst_n        (rst_n),
    .q_rd_stat    (q_rd_stat),
    .q_rd_en      (q_rd_en),
    .q_rd_data    (q_rd_data),
    .host_rd_req  (host_rd_req),
    .host_rd_addr (host_rd_addr),
    .host_rd_data (host_rd_data),
    .host_rd_ack  (host_rd_ack),
    .ts_valid     (ts_valid),
    .pop_cnt      (pop_cnt),
    .ts_irq       (ts_irq)
  );

  always #5 q_rd_clk = ~q_rd_clk;

  // tsu queue model: one-cycle read latency, registered occupancy. Data bus
  // carries random junk except in the one cycle the popped entry is valid.
  always @(posedge q_rd_clk) begin
    if (q_rd_en) begin
      rd_en_cnt <= rd_en_cnt + 1;
      if (ts_valid) overlap <= overlap + 1;
      if (src_q.size() != 0) begin
        q_rd_data <= src_q[0];
        exp_q.push_back(src_q[0]);
        void'(src_q.pop_front());
      end else begin
        underruns <= underruns + 1;
        q_rd_data <= {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      q_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end
    q_rd_stat <= 8'(src_q.size());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic host_read(input logic [1:0] a, output logic [31:0] d, output logic ack);
    host_rd_req  = 1'b1;
    host_rd_addr = a;
    @(negedge q_rd_clk);
    host_rd_req = 1'b0;
    d   = host_rd_data;
    ack = host_rd_ack;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ts_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge q_rd_clk);
    end
  endtask

  task automatic wait_rd_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (q_rd_en === 1'b1) begin ok = 1'b1; break; end
      @(negedge q_rd_clk);
    end
  endtask

  task automatic push_random();
    src_q.push_back({$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge q_rd_clk);
    checks++; if (q_rd_en !== 1'b0) begin errors++; $display("FAIL reset_q_rd_en: got %b want 0", q_rd_en); end
    checks++; if (host_rd_data !== 32'd0) begin errors++; $display("FAIL reset_host_rd_data: got %h want 0", host_rd_data); end
    checks++; if (host_rd_ack !== 1'b0) begin errors++; $display("FAIL reset_host_rd_ack: got %b want 0", host_rd_ack); end
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL reset_ts_valid: got %b want 0", ts_valid); end
    checks++; if (pop_cnt !== 16'd0) begin errors++; $display("FAIL reset_pop_cnt: got %h want 0", pop_cnt); end
    checks++; if (ts_irq !== 1'b0) begin errors++; $display("FAIL reset_ts_irq: got %b want 0", ts_irq); end
  endtask

  task automatic test_three_pops();
    bit ok;
    logic [31:0] d;
    logic ack;
    logic [127:0] e;
    int base;
    for (int i = 0; i < 3; i++) push_random();
    repeat (2) @(negedge q_rd_clk);
    base = rd_en_cnt;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL three_valid[%0d]: ts_valid never rose", i); end
      repeat (4) @(negedge q_rd_clk);
      checks++; if (rd_en_cnt - base != i + 1) begin errors++; $display("FAIL three_pulses[%0d]: got %0d want %0d", i, rd_en_cnt - base, i + 1); end
      host_read(2'd0, d, ack);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
      checks++; if (d !== e[31:0]) begin errors++; $display("FAIL three_data[%0d]: got %h want %h", i, d, e[31:0]); end
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL three_ack[%0d]: got %b want 1", i, ack); end
    end
    repeat (8) @(negedge q_rd_clk);
    checks++; if (pop_cnt !== 16'd3) begin errors++; $display("FAIL three_pop_cnt: got %0d want 3", pop_cnt); end
    checks++; if (rd_en_cnt - base != 3) begin errors++; $display("FAIL three_total_pulses: got %0d want 3", rd_en_cnt - base); end
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL three_idle_valid: got %b want 0", ts_valid); end
  endtask

  task automatic test_word_order();
    bit ok;
    logic [31:0] d;
    logic ack;
    logic [127:0] e;
    logic [1:0] a;
    src_q.push_back(128'h0123456789ABCDEF0123456789ABCDEF);
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL word_valid: ts_valid never rose"); end
    checks++; if (ts_irq !== IRQ_EN) begin errors++; $display("FAIL word_irq_capture: got %b want %b", ts_irq, IRQ_EN); end
    e = (exp_q.size() != 0) ? exp_q[0] : 128'hx;
    // addresses 3,2,1 then 3 again: non-destructive reads
    for (int k = 0; k < 4; k++) begin
      a = (k == 3) ? 2'd3 : 2'(3 - k);
      host_read(a, d, ack);
      checks++; if (d !== e[a*32 +: 32]) begin errors++; $display("FAIL word_data[addr%0d]: got %h want %h", a, d, e[a*32 +: 32]); end
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL word_ack[addr%0d]: got %b want 1", a, ack); end
    end
    checks++; if (ts_valid !== 1'b1) begin errors++; $display("FAIL word_nondestructive: ts_valid got %b want 1", ts_valid); end
    checks++; if (ts_irq !== IRQ_EN) begin errors++; $display("FAIL word_irq_hold: got %b want %b", ts_irq, IRQ_EN); end
    host_read(2'd0, d, ack);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (d !== 32'h89ABCDEF || d !== e[31:0]) begin errors++; $display("FAIL word_data[addr0]: got %h want %h", d, e[31:0]); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL word_ack[addr0]: got %b want 1", ack); end
    checks++; if (ts_irq !== 1'b0) begin errors++; $display("FAIL word_irq_pop: got %b want 0", ts_irq); end
    @(negedge q_rd_clk);
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL word_valid_after_ack: got %b want 0", ts_valid); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] d;
    logic ack;
    logic [127:0] e;
    push_random();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_valid: ts_valid never rose"); end
    e = (exp_q.size() != 0) ? exp_q[0] : 128'hx;
    host_rd_req = 1'b1; host_rd_addr = 2'd3;
    @(negedge q_rd_clk);
    host_rd_addr = 2'd2;
    checks++; if (host_rd_ack !== 1'b1 || host_rd_data !== e[127:96]) begin errors++; $display("FAIL b2b_first: ack %b data %h want ack 1 data %h", host_rd_ack, host_rd_data, e[127:96]); end
    @(negedge q_rd_clk);
    host_rd_req = 1'b0;
    checks++; if (host_rd_ack !== 1'b1 || host_rd_data !== e[95:64]) begin errors++; $display("FAIL b2b_second: ack %b data %h want ack 1 data %h", host_rd_ack, host_rd_data, e[95:64]); end
    @(negedge q_rd_clk);
    checks++; if (host_rd_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop: got %b want 0", host_rd_ack); end
    host_read(2'd0, d, ack);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (d !== e[31:0]) begin errors++; $display("FAIL b2b_pop: got %h want %h", d, e[31:0]); end
  endtask

  task automatic test_settle();
    bit ok;
    logic [31:0] d;
    logic ack;
    logic [127:0] e;
    push_random();
    push_random();
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL settle_valid: ts_valid never rose"); end
    host_read(2'd0, d, ack);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (d !== e[31:0]) begin errors++; $display("FAIL settle_first_data: got %h want %h", d, e[31:0]); end
    // queue still reports 1 entry; the reader must sit out the settle window
    for (int i = 0; i <= STAT_SETTLE; i++) begin
      checks++; if (q_rd_en !== 1'b0) begin errors++; $display("FAIL settle_quiet[%0d]: q_rd_en got %b want 0", i, q_rd_en); end
      @(negedge q_rd_clk);
    end
    wait_rd_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL settle_next_pop: q_rd_en never rose"); end
    wait_valid(ok);
    host_read(2'd0, d, ack);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (d !== e[31:0]) begin errors++; $display("FAIL settle_second_data: got %h want %h", d, e[31:0]); end
  endtask

  task automatic test_empty_read();
    logic [31:0] d;
    logic ack;
    logic [15:0] pc;
    repeat (6) @(negedge q_rd_clk);
    pc = pop_cnt;
    host_read(2'd0, d, ack);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL empty_data: got %h want 0", d); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL empty_ack: got %b want 1", ack); end
    checks++; if (pop_cnt !== pc) begin errors++; $display("FAIL empty_pop_cnt: got %0d want %0d", pop_cnt, pc); end
    host_read(2'd2, d, ack);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL empty_data_addr2: got %h want 0", d); end
    checks++; if (ts_valid !== 1'b0) begin errors++; $display("FAIL empty_valid: got %b want 0", ts_valid); end
  endtask

  task automatic test_read_during_fetch();
    bit ok;
    logic [31:0] d;
    logic ack;
    logic [127:0] e;
    push_random();
    wait_rd_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL fetch_rd_en: q_rd_en never rose"); end
    host_rd_req = 1'b1; host_rd_addr = 2'd3;
    @(negedge q_rd_clk);
    checks++; if (host_rd_ack !== 1'b1 || host_rd_data !== 32'd0) begin errors++; $display("FAIL fetch_read_req: ack %b data %h want ack 1 data 0", host_rd_ack, host_rd_data); end
    @(negedge q_rd_clk);
    host_rd_req = 1'b0;
    checks++; if (host_rd_ack !== 1'b1 || host_rd_data !== 32'd0) begin errors++; $display("FAIL fetch_read_wait: ack %b data %h want ack 1 data 0", host_rd_ack, host_rd_data); end
    checks++; if (ts_valid !== 1'b1) begin errors++; $display("FAIL fetch_capture: ts_valid got %b want 1", ts_valid); end
    host_read(2'd0, d, ack);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (d !== e[31:0]) begin errors++; $display("FAIL fetch_data: got %h want %h", d, e[31:0]); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    logic [31:0] d;
    logic ack;
    logic [127:0] e;
    int base;
    repeat (6) @(negedge q_rd_clk);
    push_random();
    wait_rd_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstw_rd_en: q_rd_en never rose"); end
    @(negedge q_rd_clk);  // now in the read-latency wait
    #1 rst_n = 1'b0;
    #1;
    checks++; if (q_rd_en !== 1'b0 || ts_valid !== 1'b0 || ts_irq !== 1'b0) begin errors++; $display("FAIL rstw_ctrl: q_rd_en %b ts_valid %b ts_irq %b want 0", q_rd_en, ts_valid, ts_irq); end
    checks++; if (pop_cnt !== 16'd0) begin errors++; $display("FAIL rstw_pop_cnt: got %0d want 0", pop_cnt); end
    checks++; if (host_rd_ack !== 1'b0 || host_rd_data !== 32'd0) begin errors++; $display("FAIL rstw_host: ack %b data %h want 0", host_rd_ack, host_rd_data); end
    exp_q.delete();  // the in-flight entry is lost by design
    @(negedge q_rd_clk);
    push_random();
    repeat (2) @(negedge q_rd_clk);
    base = rd_en_cnt;
    rst_n = 1'b1;
    wait_rd_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstw_fresh_pop: q_rd_en never rose"); end
    wait_valid(ok);
    repeat (5) @(negedge q_rd_clk);
    checks++; if (rd_en_cnt - base != 1) begin errors++; $display("FAIL rstw_pulses: got %0d want 1", rd_en_cnt - base); end
    checks++; if (pop_cnt !== 16'd1) begin errors++; $display("FAIL rstw_pop_cnt_after: got %0d want 1", pop_cnt); end
    host_read(2'd0, d, ack);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
    checks++; if (d !== e[31:0]) begin errors++; $display("FAIL rstw_data: got %h want %h", d, e[31:0]); end
  endtask

  initial begin
    rst_n        = 1'b0;
    host_rd_req  = 1'b0;
    host_rd_addr = 2'd0;
    test_reset();
    test_three_pops();
    test_word_order();
    test_back_to_back();
    test_settle();
    test_empty_read();
    test_read_during_fetch();
    test_reset_in_wait();
    repeat (4) @(negedge q_rd_clk);
    checks++; if (underruns != 0) begin errors++; $display("FAIL underrun: got %0d want 0", underruns); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL pop_while_valid: got %0d want 0", overlap); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
